mixer_fifo_arbiter: RTL and testbench

MIXER_FIFO_ARBITER -- requirements
Module: mixer_fifo_arbiter

---
 rtl/audio_fx_pkg.sv | 20 ++
 rtl/mixer_fifo_arbiter_rr_pick.sv | 40 ++++
 rtl/mixer_fifo_arbiter.sv | 152 +++++++++++++++
 tb/tb_mixer_fifo_arbiter.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_fx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : audio_fx_pkg
// Description : Shared definitions for the effect-mixer FIFO arbiter:
//               FSM state encodings, default sample width and the width
//               of the FIFO-full stall counter.
// Revision    : 1.0 - initial release
// ============================================================================
package audio_fx_pkg;

  localparam int DEFAULT_DATA_WIDTH = 16;
  localparam int STALL_CNT_W        = 16;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/mixer_fifo_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin selector. Searches the eligible
//               vector starting one past the last grant, wrapping from
//               n_req-1 back to 0, and reports the first hit.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
  parameter int n_req = 4,
  parameter int gw    = 2
) (
  input  logic [n_req-1:0] i_eligible,
  input  logic [gw-1:0]    i_last_grant,
  output logic [gw-1:0]    o_winner,
  output logic             o_any_eligible
);

  int w_idx;

  // Walk offsets from farthest to nearest so the nearest eligible
  // requester (highest priority) is the one left standing.
  always_comb begin
    o_winner       = '0;
    o_any_eligible = 1'b0;
    w_idx          = 0;
    for (int off = n_req; off >= 1; off--) begin
      w_idx = int'(i_last_grant) + off;
      if (w_idx >= n_req) begin
        w_idx = w_idx - n_req;
      end
      if (i_eligible[w_idx]) begin
        o_winner       = w_idx[gw-1:0];
        o_any_eligible = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mixer_fifo_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mixer_fifo_arbiter
// Description : Round-robin arbiter that collects signed samples from n_req
//               effect requesters and writes them one at a time into an
//               output FIFO. Two-state FSM (IDLE/WRITE), fully registered
//               outputs, peak throughput one sample per two cycles.
//               Optional feature: define MIXER_ARB_STATS_EN to build a
//               saturating counter of FIFO-full stall cycles on o_stall_cnt;
//               otherwise o_stall_cnt is tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module mixer_fifo_arbiter
  import audio_fx_pkg::*;
#(
  parameter int data_width = DEFAULT_DATA_WIDTH,
  parameter int n_req      = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [n_req-1:0]            i_req_valid,
  input  logic [n_req*data_width-1:0] i_req_data,
  input  logic [n_req-1:0]            i_req_mask,
  output logic [n_req-1:0]            o_req_ready,
  input  logic                        i_fifo_full,
  output logic [data_width-1:0]       o_fifo_data,
  output logic                        o_fifo_wr,
  output logic [$clog2(n_req)-1:0]    o_grant_id,
  output logic                        o_busy,
  output logic [STALL_CNT_W-1:0]      o_stall_cnt
);

  localparam int GW = $clog2(n_req);

  arb_state_t            r_state;
  arb_state_t            w_state_nxt;
  logic [n_req-1:0]      w_eligible;
  logic [n_req-1:0]      r_ready;
  logic [n_req-1:0]      w_ready_nxt;
  logic [GW-1:0]         w_winner;
  logic                  w_any;
  logic [GW-1:0]         r_last;
  logic [GW-1:0]         w_last_nxt;
  logic [GW-1:0]         r_gid;
  logic [GW-1:0]         w_gid_nxt;
  logic [data_width-1:0] r_cap;
  logic [data_width-1:0] w_cap_nxt;
  logic [data_width-1:0] r_fifo_data;
  logic [data_width-1:0] w_fifo_data_nxt;
  logic                  r_wr;
  logic                  w_wr_nxt;
  logic                  r_busy;

  assign w_eligible = i_req_valid & i_req_mask;

  rr_pick #(
    .n_req (n_req),
    .gw    (GW)
  ) u_rr_pick (
    .i_eligible     (w_eligible),
    .i_last_grant   (r_last),
    .o_winner       (w_winner),
    .o_any_eligible (w_any)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state plus next values of every registered output / capture reg.
  always_comb begin
    w_state_nxt     = r_state;
    w_ready_nxt     = '0;
    w_wr_nxt        = 1'b0;
    w_fifo_data_nxt = r_fifo_data;
    w_cap_nxt       = r_cap;
    w_last_nxt      = r_last;
    w_gid_nxt       = r_gid;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_ready_nxt[w_winner] = 1'b1;
          w_cap_nxt   = i_req_data[int'(w_winner)*data_width +: data_width];
          w_last_nxt  = w_winner;
          w_gid_nxt   = w_winner;
          w_state_nxt = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (!i_fifo_full) begin
          w_wr_nxt        = 1'b1;
          w_fifo_data_nxt = r_cap;
          w_state_nxt     = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Output and capture registers; reset drops any captured sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ready     <= '0;
      r_wr        <= 1'b0;
      r_fifo_data <= '0;
      r_cap       <= '0;
      r_last      <= GW'(n_req - 1);
      r_gid       <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_ready     <= w_ready_nxt;
      r_wr        <= w_wr_nxt;
      r_fifo_data <= w_fifo_data_nxt;
      r_cap       <= w_cap_nxt;
      r_last      <= w_last_nxt;
      r_gid       <= w_gid_nxt;
      r_busy      <= (w_state_nxt == ST_WRITE);
    end
  end

`ifdef MIXER_ARB_STATS_EN
  logic [STALL_CNT_W-1:0] r_stall_cnt;

  // Saturating count of WRITE cycles blocked by a full FIFO.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if ((r_state == ST_WRITE) && i_fifo_full && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign o_stall_cnt = r_stall_cnt;
`else
  assign o_stall_cnt = '0;
`endif

  assign o_req_ready = r_ready;
  assign o_fifo_wr   = r_wr;
  assign o_fifo_data = r_fifo_data;
  assign o_grant_id  = r_gid;
  assign o_busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_mixer_fifo_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mixer_fifo_arbiter
// Description : Self-checking bench for mixer_fifo_arbiter. A transaction
//               level reference (pending-sample queue + round-robin pointer)
//               predicts every registered output each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mixer_fifo_arbiter;

  localparam int N  = 4;
  localparam int DW = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    i_req_valid;
  logic [N*DW-1:0] i_req_data;
  logic [N-1:0]    i_req_mask;
  logic            i_fifo_full;
  logic [N-1:0]    o_req_ready;
  logic [DW-1:0]   o_fifo_data;
  logic            o_fifo_wr;
  logic [1:0]      o_grant_id;
  logic            o_busy;
  logic [15:0]     o_stall_cnt;

  always #5 clk = ~clk;

  mixer_fifo_arbiter #(
    .data_width (DW),
    .n_req      (N)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .i_req_valid (i_req_valid),
    .i_req_data  (i_req_data),
    .i_req_mask  (i_req_mask),
    .o_req_ready (o_req_ready),
    .i_fifo_full (i_fifo_full),
    .o_fifo_data (o_fifo_data),
    .o_fifo_wr   (o_fifo_wr),
    .o_grant_id  (o_grant_id),
    .o_busy      (o_busy),
    .o_stall_cnt (o_stall_cnt)
  );

`ifdef MIXER_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [DW-1:0] m_pend[$];
  int            m_last;
  logic [N-1:0]  e_ready;
  logic          e_wr;
  logic [DW-1:0] e_data;
  int            e_gid;
  int            e_stall;

  int grants[$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  // One clock edge of the reference: at most one sample in flight;
  // an empty slot is filled by the nearest eligible requester after the
  // last grant, a held sample is emitted when the FIFO has room.
  task automatic model_edge();
    logic [N-1:0] elig;
    if (reset) begin
      m_pend.delete();
      m_last  = N - 1;
      e_ready = '0;
      e_wr    = 1'b0;
      e_data  = '0;
      e_gid   = 0;
      e_stall = 0;
      return;
    end
    e_ready = '0;
    e_wr    = 1'b0;
    if (m_pend.size() == 0) begin
      elig = i_req_valid & i_req_mask;
      for (int off = 1; off <= N; off++) begin
        int k;
        k = (m_last + off) % N;
        if (elig[k] && m_pend.size() == 0) begin
          m_pend.push_back(i_req_data[k*DW +: DW]);
          e_ready[k] = 1'b1;
          m_last     = k;
          e_gid      = k;
        end
      end
    end else if (!i_fifo_full) begin
      e_wr   = 1'b1;
      e_data = m_pend.pop_front();
    end else if (STATS && e_stall < 16'hFFFF) begin
      e_stall++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("ready", 32'(o_req_ready), 32'(e_ready));
    chk("wr",    32'(o_fifo_wr),   32'(e_wr));
    chk("data",  32'(o_fifo_data), 32'(e_data));
    chk("gid",   32'(o_grant_id),  32'(e_gid));
    chk("busy",  32'(o_busy),      32'(m_pend.size() != 0));
    chk("stall", 32'(o_stall_cnt), 32'(e_stall));
    if (o_req_ready != '0) grants.push_back(int'(o_grant_id));
  endtask

  // Requesters: on acknowledge, either present a fresh sample or drop valid.
  task automatic req_update(input bit rnd);
    for (int k = 0; k < N; k++) begin
      if (o_req_ready[k]) begin
        i_req_data[k*DW +: DW] = DW'($urandom);
        i_req_valid[k] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      end else if (rnd && !i_req_valid[k] && $urandom_range(0, 2) == 0) begin
        i_req_valid[k] = 1'b1;
        i_req_data[k*DW +: DW] = DW'($urandom);
      end
    end
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    i_req_valid = '0;
    i_req_mask  = '1;
    i_fifo_full = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    i_req_data = '0;
    do_reset();

    // Single request from requester 1
    i_req_valid = 4'b0010;
    i_req_data[1*DW +: DW] = 16'h1234;
    step();
    chk("t030_ready", 32'(o_req_ready), 32'h2);
    i_req_valid = '0;
    step();
    chk("t030_wr",   32'(o_fifo_wr),   32'h1);
    chk("t030_data", 32'(o_fifo_data), 32'h1234);
    chk("t030_gid",  32'(o_grant_id),  32'h1);

    // All valid, full mask: strict rotation
    do_reset();
    grants.delete();
    i_req_valid = '1;
    for (int i = 0; i < 12; i++) begin
      step();
      req_update(1'b0);
    end
    chk("t031_ngrants", 32'(grants.size()), 32'd6);
    for (int i = 0; i < 6 && i < grants.size(); i++)
      chk("t031_order", 32'(grants[i]), 32'(i % 4));

    // Mask 0101: only requesters 0 and 2
    do_reset();
    grants.delete();
    i_req_valid = '1;
    i_req_mask  = 4'b0101;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("t032_no13", 32'(o_req_ready & 4'b1010), 32'h0);
      req_update(1'b0);
    end
    chk("t032_ngrants", 32'(grants.size()), 32'd4);
    for (int i = 0; i < 4 && i < grants.size(); i++)
      chk("t032_order", 32'(grants[i]), 32'((i % 2) * 2));

    // Stall for 5 cycles in WRITE
    do_reset();
    i_req_valid = 4'b0100;
    i_req_data[2*DW +: DW] = 16'h8001;
    step();
    i_req_valid = '0;
    i_fifo_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t033_nowr", 32'(o_fifo_wr), 32'h0);
    end
    i_fifo_full = 1'b0;
    step();
    chk("t033_wr",    32'(o_fifo_wr),   32'h1);
    chk("t033_data",  32'(o_fifo_data), 32'h8001);
    chk("t033_stall", 32'(o_stall_cnt), STATS ? 32'd5 : 32'd0);
    step();
    chk("t033_single", 32'(o_fifo_wr), 32'h0);

    // Reset while in WRITE
    i_req_valid = 4'b1000;
    step();
    i_req_valid = '0;
    do_reset();
    chk("t034_nowr", 32'(o_fifo_wr), 32'h0);
    i_req_valid = '1;
    step();
    chk("t034_first", 32'(o_req_ready), 32'h1);
    step();
    chk("t034_wr", 32'(o_fifo_wr), 32'h1);

    // Randomized traffic with occasional resets
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      i_fifo_full = ($urandom_range(0, 9) < 3);
      if ($urandom_range(0, 19) == 0) i_req_mask = 4'($urandom);
      reset = ($urandom_range(0, 199) == 0);
      step();
      req_update(1'b1);
    end
    reset = 1'b0;

`ifdef MIXER_ARB_STATS_EN
    // Long stall: counter saturates
    do_reset();
    i_req_valid = 4'b0001;
    step();
    i_req_valid = '0;
    i_fifo_full = 1'b1;
    for (int i = 0; i < 70000; i++) step();
    chk("t035_sat", 32'(o_stall_cnt), 32'hFFFF);
    i_fifo_full = 1'b0;
    step();
    chk("t035_wr", 32'(o_fifo_wr), 32'h1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
